// File: rtl/fwd_a_unit.sv
// Decode-stage operand-A forwarding: picks the freshest srcA value from E/M/W
// results or the register file, and latches it into the D/E slot for valA.
module fwd_a_unit #(
  parameter int         W     = 32,
  parameter logic [4:0] RNONE = 5'b11111
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   d_srcA,
  input  logic [4:0]   E_dstE,
  input  logic [4:0]   M_dstM,
  input  logic [4:0]   M_dstE,
  input  logic [4:0]   W_dstM,
  input  logic [4:0]   W_dstE,
  input  logic [W-1:0] d_rvalA,
  input  logic [W-1:0] e_valE,
  input  logic [W-1:0] m_valM,
  input  logic [W-1:0] M_valE,
  input  logic [W-1:0] W_valM,
  input  logic [W-1:0] W_valE,
  input  logic         E_stall,
  input  logic         E_bubble,
  output logic [W-1:0] d_valA,
  output logic [2:0]   d_fwdsel,
  output logic [W-1:0] E_valA,
  output logic [4:0]   E_srcA
);

  typedef enum logic [2:0] {
    SEL_RF   = 3'd0,
    SEL_EE   = 3'd1,
    SEL_MM   = 3'd2,
    SEL_ME   = 3'd3,
    SEL_WM   = 3'd4,
    SEL_WE   = 3'd5
  } fwd_sel_e;

  fwd_sel_e       sel;
  logic           no_fwd;
  logic [W-1:0]   e_vala_d, e_vala_q;
  logic [4:0]     e_srca_d, e_srca_q;

  // $0 and RNONE short-circuit before any dst compare, so X on dst inputs
  // cannot leak into the selection when nothing should be forwarded.
  assign no_fwd = (d_srcA == RNONE) || (d_srcA == 5'd0);

  // Youngest stage wins; within M and W the load result beats the ALU result.
  always_comb begin
    sel = SEL_RF;
    if (no_fwd)                   sel = SEL_RF;
    else if (d_srcA == E_dstE)    sel = SEL_EE;
    else if (d_srcA == M_dstM)    sel = SEL_MM;
    else if (d_srcA == M_dstE)    sel = SEL_ME;
    else if (d_srcA == W_dstM)    sel = SEL_WM;
    else if (d_srcA == W_dstE)    sel = SEL_WE;
  end

  always_comb begin
    d_valA = d_rvalA;
    unique case (sel)
      SEL_EE:  d_valA = e_valE;
      SEL_MM:  d_valA = m_valM;
      SEL_ME:  d_valA = M_valE;
      SEL_WM:  d_valA = W_valM;
      SEL_WE:  d_valA = W_valE;
      default: d_valA = d_rvalA;
    endcase
  end

  assign d_fwdsel = sel;

  // Bubble beats stall; a bubble carries no source register.
  always_comb begin
    e_vala_d = e_vala_q;
    e_srca_d = e_srca_q;
    if (E_bubble) begin
      e_vala_d = '0;
      e_srca_d = RNONE;
    end else if (!E_stall) begin
      e_vala_d = d_valA;
      e_srca_d = d_srcA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_vala_q <= '0;
      e_srca_q <= RNONE;
    end else begin
      e_vala_q <= e_vala_d;
      e_srca_q <= e_srca_d;
    end
  end

  assign E_valA = e_vala_q;
  assign E_srcA = e_srca_q;

endmodule

// File: tb/tb_fwd_a_unit.sv
// Directed bench for fwd_a_unit: table of combinational forwarding vectors
// followed by hand-written sequences for the registered D/E slot.
module tb_fwd_a_unit;
  localparam int         W     = 32;
  localparam logic [4:0] RNONE = 5'b11111;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   d_srcA, E_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [W-1:0] d_rvalA, e_valE, m_valM, M_valE, W_valM, W_valE;
  logic         E_stall, E_bubble;
  logic [W-1:0] d_valA, E_valA;
  logic [2:0]   d_fwdsel;
  logic [4:0]   E_srcA;

  int n_pass  = 0;
  int n_total = 0;

  fwd_a_unit #(.W(W), .RNONE(RNONE)) dut (
    .clk(clk), .reset(reset),
    .d_srcA(d_srcA), .E_dstE(E_dstE), .M_dstM(M_dstM), .M_dstE(M_dstE),
    .W_dstM(W_dstM), .W_dstE(W_dstE),
    .d_rvalA(d_rvalA), .e_valE(e_valE), .m_valM(m_valM), .M_valE(M_valE),
    .W_valM(W_valM), .W_valE(W_valE),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .d_valA(d_valA), .d_fwdsel(d_fwdsel), .E_valA(E_valA), .E_srcA(E_srcA)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [4:0]   src, ee, mm, me, wm, we;
    logic [W-1:0] rv, vee, vmm, vme, vwm, vwe;
    logic [W-1:0] exp_val;
    logic [2:0]   exp_sel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic [4:0] src, logic [4:0] ee, logic [4:0] mm,
                              logic [4:0] me, logic [4:0] wm, logic [4:0] we,
                              logic [W-1:0] rv, logic [W-1:0] vee, logic [W-1:0] vmm,
                              logic [W-1:0] vme, logic [W-1:0] vwm, logic [W-1:0] vwe,
                              logic [W-1:0] ev, logic [2:0] es);
    vec_t v;
    v.name = nm; v.src = src; v.ee = ee; v.mm = mm; v.me = me; v.wm = wm; v.we = we;
    v.rv = rv; v.vee = vee; v.vmm = vmm; v.vme = vme; v.vwm = vwm; v.vwe = vwe;
    v.exp_val = ev; v.exp_sel = es;
    return v;
  endfunction

  task automatic check(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic apply(vec_t v);
    d_srcA = v.src; E_dstE = v.ee; M_dstM = v.mm; M_dstE = v.me; W_dstM = v.wm; W_dstE = v.we;
    d_rvalA = v.rv; e_valE = v.vee; m_valM = v.vmm; M_valE = v.vme; W_valM = v.vwm; W_valE = v.vwe;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; E_stall = 1'b0; E_bubble = 1'b0;
    d_srcA = RNONE; E_dstE = RNONE; M_dstM = RNONE; M_dstE = RNONE; W_dstM = RNONE; W_dstE = RNONE;
    d_rvalA = '0; e_valE = '0; m_valM = '0; M_valE = '0; W_valM = '0; W_valE = '0;

    //            name        src       ee        mm        me        wm        we        rv vee vmm vme vwm vwe  val sel
    vecs.push_back(mk("rf_zero",  5'd0,     RNONE,    RNONE,    RNONE,    RNONE,    RNONE,    0, 0, 0, 0, 0, 0,   0, 0));
    vecs.push_back(mk("rf_rnone", RNONE,    RNONE,    RNONE,    RNONE,    RNONE,    RNONE,    1, 0, 0, 0, 0, 0,   1, 0));
    vecs.push_back(mk("zero_nofwd", 5'd0,   5'd0,     5'd0,     5'd0,     5'd0,     5'd0,     9, 90, 91, 92, 93, 94, 9, 0));
    vecs.push_back(mk("fwd_eE",   5'b10101, 5'b10101, RNONE,    RNONE,    RNONE,    RNONE,    0, 2, 0, 0, 0, 0,   2, 1));
    vecs.push_back(mk("fwd_ME",   5'b10110, 5'b10101, RNONE,    5'b10110, RNONE,    RNONE,    0, 2, 0, 3, 0, 0,   3, 3));
    vecs.push_back(mk("fwd_mM",   5'b10111, 5'b10101, 5'b10111, 5'b10110, RNONE,    RNONE,    0, 2, 4, 3, 0, 0,   4, 2));
    vecs.push_back(mk("fwd_WE",   5'b11000, 5'b10101, 5'b10111, 5'b10110, RNONE,    5'b11000, 0, 2, 4, 3, 0, 5,   5, 5));
    vecs.push_back(mk("fwd_WM",   5'b11001, 5'b10101, 5'b10111, 5'b10110, 5'b11001, 5'b11000, 0, 2, 4, 3, 6, 5,   6, 4));
    vecs.push_back(mk("no_match", 5'b11010, 5'd1,     5'd2,     5'd3,     5'd4,     5'd5,     7, 2, 4, 3, 6, 5,   7, 0));
    vecs.push_back(mk("pri_all",  5'b00111, 5'b00111, 5'b00111, 5'b00111, 5'b00111, 5'b00111, 99, 10, 11, 12, 13, 14, 10, 1));
    vecs.push_back(mk("pri_noE",  5'b00111, 5'd1,     5'b00111, 5'b00111, 5'b00111, 5'b00111, 99, 10, 11, 12, 13, 14, 11, 2));
    vecs.push_back(mk("pri_noMM", 5'b00111, 5'd1,     5'd2,     5'b00111, 5'b00111, 5'b00111, 99, 10, 11, 12, 13, 14, 12, 3));
    vecs.push_back(mk("pri_noME", 5'b00111, 5'd1,     5'd2,     5'd3,     5'b00111, 5'b00111, 99, 10, 11, 12, 13, 14, 13, 4));
    vecs.push_back(mk("pri_noWM", 5'b00111, 5'd1,     5'd2,     5'd3,     5'd4,     5'b00111, 99, 10, 11, 12, 13, 14, 14, 5));
    vecs.push_back(mk("pri_none", 5'b00111, 5'd1,     5'd2,     5'd3,     5'd4,     5'd5,     99, 10, 11, 12, 13, 14, 99, 0));
    vecs.push_back(mk("rnone_dst", RNONE,   RNONE,    RNONE,    RNONE,    RNONE,    RNONE,    42, 10, 11, 12, 13, 14, 42, 0));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      check({vecs[i].name, ".val"}, d_valA, vecs[i].exp_val);
      check({vecs[i].name, ".sel"}, {29'd0, d_fwdsel}, {29'd0, vecs[i].exp_sel});
    end

    // Registered slot sequences
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("rst.valA", E_valA, 0);
    check("rst.srcA", {27'd0, E_srcA}, {27'd0, RNONE});

    @(negedge clk);
    reset = 1'b0;
    d_srcA = 5'b10101; E_dstE = 5'b10101; M_dstM = RNONE; M_dstE = RNONE; W_dstM = RNONE; W_dstE = RNONE;
    e_valE = 2; d_rvalA = 77;
    tick();
    check("latch.valA", E_valA, 2);
    check("latch.srcA", {27'd0, E_srcA}, {27'd0, 5'b10101});

    @(negedge clk);
    E_stall = 1'b1; e_valE = 3; d_srcA = 5'b10101;
    #1;
    check("stall.dvalA", d_valA, 3);
    tick();
    check("stall.valA", E_valA, 2);
    check("stall.srcA", {27'd0, E_srcA}, {27'd0, 5'b10101});

    @(negedge clk);
    E_bubble = 1'b1;
    tick();
    check("bubble.valA", E_valA, 0);
    check("bubble.srcA", {27'd0, E_srcA}, {27'd0, RNONE});

    @(negedge clk);
    E_bubble = 1'b0; E_stall = 1'b0;
    tick();
    check("resume.valA", E_valA, 3);

    @(negedge clk);
    reset = 1'b1;
    tick();
    check("midrst.valA", E_valA, 0);
    check("midrst.srcA", {27'd0, E_srcA}, {27'd0, RNONE});
    check("midrst.dvalA", d_valA, 3);
    check("midrst.sel", {29'd0, d_fwdsel}, 1);

    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_rst.valA", E_valA, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
